// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Commits write values in order; operand lookup resolves to a value or the pending ROB id.
module reg_file #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 dec_ready,
    input  logic [4:0]           dec_rd,
    input  logic [ROB_WIDTH-1:0] dec_rob_id,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic [31:0]          val1,
    output logic                 dep1,
    output logic [ROB_WIDTH-1:0] dep_rob_id1,
    output logic [31:0]          val2,
    output logic                 dep2,
    output logic [ROB_WIDTH-1:0] dep_rob_id2,
    output logic [ROB_WIDTH-1:0] search_rob_id_1,
    input  logic                 search_ready_1,
    input  logic [31:0]          search_val_1,
    output logic [ROB_WIDTH-1:0] search_rob_id_2,
    input  logic                 search_ready_2,
    input  logic [31:0]          search_val_2,
    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [4:0]           commit_reg_id,
    input  logic [31:0]          commit_val
);

    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [DATA_W-1:0]    val;
        logic                 dep;
        logic [ROB_WIDTH-1:0] rob;
    } opnd_t;

    logic [DATA_W-1:0]    value_q [NREG];
    logic [ROB_WIDTH-1:0] tag_q   [NREG];
    logic [NREG-1:0]      busy_q;

    logic commit_en;
    logic issue_en;
    logic commit_retires;

    assign commit_en      = commit_ready && (commit_reg_id != 5'd0);
    assign issue_en       = dec_ready && (dec_rd != 5'd0) && !clear;
    // A commit only frees the register if it comes from the newest producer.
    assign commit_retires = commit_en && (tag_q[commit_reg_id] == commit_rob_id);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            if (commit_en) begin
                value_q[commit_reg_id] <= commit_val;
            end
            if (clear) begin
                busy_q <= '0;
            end else begin
                if (commit_retires) begin
                    busy_q[commit_reg_id] <= 1'b0;
                end
                // Issue is last so a same-cycle rename keeps the register busy.
                if (issue_en) begin
                    busy_q[dec_rd] <= 1'b1;
                    tag_q[dec_rd]  <= dec_rob_id;
                end
            end
        end
    end

    function automatic opnd_t resolve(
        input logic [4:0]           rs,
        input logic [DATA_W-1:0]    rval,
        input logic                 rbusy,
        input logic [ROB_WIDTH-1:0] rtag,
        input logic                 commit_hit,
        input logic [DATA_W-1:0]    cval,
        input logic                 s_rdy,
        input logic [DATA_W-1:0]    s_val
    );
        opnd_t o;
        o.val = '0;
        o.dep = 1'b0;
        o.rob = '0;
        if (rs == 5'd0) begin
            o.val = '0;
        end else if (!rbusy) begin
            o.val = rval;
        end else if (commit_hit) begin
            o.val = cval;
        end else if (s_rdy) begin
            o.val = s_val;
        end else begin
            o.dep = 1'b1;
            o.rob = rtag;
        end
        return o;
    endfunction

    opnd_t op1;
    opnd_t op2;
    logic  hit1;
    logic  hit2;

    assign hit1 = commit_ready && (commit_reg_id == rs1) && (commit_rob_id == tag_q[rs1]);
    assign hit2 = commit_ready && (commit_reg_id == rs2) && (commit_rob_id == tag_q[rs2]);

    always_comb begin
        op1 = resolve(rs1, value_q[rs1], busy_q[rs1], tag_q[rs1], hit1, commit_val,
                      search_ready_1, search_val_1);
        op2 = resolve(rs2, value_q[rs2], busy_q[rs2], tag_q[rs2], hit2, commit_val,
                      search_ready_2, search_val_2);
    end

    assign val1            = op1.val;
    assign dep1            = op1.dep;
    assign dep_rob_id1     = op1.rob;
    assign val2            = op2.val;
    assign dep2            = op2.dep;
    assign dep_rob_id2     = op2.rob;
    assign search_rob_id_1 = tag_q[rs1];
    assign search_rob_id_2 = tag_q[rs2];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected operand results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic          dec_ready;
    logic [4:0]    dec_rd;
    logic [RW-1:0] dec_rob_id;
    logic [4:0]    rs1, rs2;
    logic [31:0]   val1, val2;
    logic          dep1, dep2;
    logic [RW-1:0] dep_rob_id1, dep_rob_id2;
    logic [RW-1:0] search_rob_id_1, search_rob_id_2;
    logic          search_ready_1, search_ready_2;
    logic [31:0]   search_val_1, search_val_2;
    logic          commit_ready;
    logic [RW-1:0] commit_rob_id;
    logic [4:0]    commit_reg_id;
    logic [31:0]   commit_val;

    reg_file #(.ROB_WIDTH(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .dec_ready(dec_ready), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
        .rs1(rs1), .rs2(rs2),
        .val1(val1), .dep1(dep1), .dep_rob_id1(dep_rob_id1),
        .val2(val2), .dep2(dep2), .dep_rob_id2(dep_rob_id2),
        .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1),
        .search_val_1(search_val_1),
        .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2),
        .search_val_2(search_val_2),
        .commit_ready(commit_ready), .commit_rob_id(commit_rob_id),
        .commit_reg_id(commit_reg_id), .commit_val(commit_val)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string         name;
        int            port;
        logic [31:0]   val;
        logic          dep;
        logic [RW-1:0] rob;
        logic [RW-1:0] sid;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_op(input string name, input int port, input logic [31:0] v,
                             input logic d, input logic [RW-1:0] r, input logic [RW-1:0] s);
        exp_t e;
        e.name = name; e.port = port; e.val = v; e.dep = d; e.rob = r; e.sid = s;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear = 1'b0;
        dec_ready = 1'b0; dec_rd = '0; dec_rob_id = '0;
        rs1 = '0; rs2 = '0;
        search_ready_1 = 1'b0; search_val_1 = '0;
        search_ready_2 = 1'b0; search_val_2 = '0;
        commit_ready = 1'b0; commit_rob_id = '0; commit_reg_id = '0; commit_val = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RW-1:0] rob);
        dec_ready = 1'b1; dec_rd = rd; dec_rob_id = rob;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [RW-1:0] rob, input logic [31:0] v);
        commit_ready = 1'b1; commit_reg_id = rd; commit_rob_id = rob; commit_val = v;
    endtask

    // Monitor: operands are valid every cycle, sample everything queued on the falling edge.
    always @(negedge clk_in) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0]   gv;
            logic          gd;
            logic [RW-1:0] gr, gs;
            e = exp_q.pop_front();
            if (e.port == 1) begin
                gv = val1; gd = dep1; gr = dep_rob_id1; gs = search_rob_id_1;
            end else begin
                gv = val2; gd = dep2; gr = dep_rob_id2; gs = search_rob_id_2;
            end
            n_checks++;
            if (gv === e.val && gd === e.dep && (!e.dep || gr === e.rob) && gs === e.sid) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got val=%h dep=%b rob=%0d sid=%0d, want val=%h dep=%b rob=%0d sid=%0d",
                         e.name, gv, gd, gr, gs, e.val, e.dep, e.rob, e.sid);
            end
        end
    end

    initial begin
        idle();
        rst_in = 1'b1;
        rs1 = 5'd5; rs2 = 5'd31;
        expect_op("reset_rs1", 1, 32'h0, 1'b0, 0, 0);
        expect_op("reset_rs2", 2, 32'h0, 1'b0, 0, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Issue x3 <- rob2; the same-cycle lookup must see the pre-issue state.
        tick(); issue(5'd3, 4'd2); rs1 = 5'd3;
        expect_op("pre_issue", 1, 32'h0, 1'b0, 0, 0);
        tick(); rs1 = 5'd3;
        expect_op("dep_x3", 1, 32'h0, 1'b1, 4'd2, 4'd2);
        tick(); rs1 = 5'd3; search_ready_1 = 1'b1; search_val_1 = 32'h55;
        expect_op("search_x3", 1, 32'h55, 1'b0, 0, 4'd2);
        tick(); commit(5'd3, 4'd2, 32'hDEADBEEF); rs2 = 5'd3;
        expect_op("bypass_x3", 2, 32'hDEADBEEF, 1'b0, 0, 4'd2);
        tick(); rs2 = 5'd3;
        expect_op("retired_x3", 2, 32'hDEADBEEF, 1'b0, 0, 4'd2);

        // Stale commit on x4.
        tick(); issue(5'd4, 4'd1);
        tick(); issue(5'd4, 4'd5);
        tick(); commit(5'd4, 4'd1, 32'd7); rs1 = 5'd4;
        expect_op("stale_commit", 1, 32'h0, 1'b1, 4'd5, 4'd5);
        tick(); rs1 = 5'd4; rs2 = 5'd4; search_ready_2 = 1'b1; search_val_2 = 32'h1234;
        expect_op("stale_after", 1, 32'h0, 1'b1, 4'd5, 4'd5);
        expect_op("stale_search2", 2, 32'h1234, 1'b0, 0, 4'd5);

        // Same-cycle issue and commit on x6.
        tick(); issue(5'd6, 4'd3); commit(5'd6, 4'd0, 32'd9);
        tick(); rs1 = 5'd6;
        expect_op("issue_commit_x6", 1, 32'h0, 1'b1, 4'd3, 4'd3);

        // Commit bypass takes priority over the search port.
        tick(); issue(5'd12, 4'd6);
        tick(); commit(5'd12, 4'd6, 32'h111); rs1 = 5'd12;
        search_ready_1 = 1'b1; search_val_1 = 32'h222;
        expect_op("bypass_over_search", 1, 32'h111, 1'b0, 0, 4'd6);

        // Clear drops busy bits, ignores issue, still commits.
        tick(); issue(5'd1, 4'd7);
        tick(); issue(5'd2, 4'd8);
        tick(); rs1 = 5'd1; rs2 = 5'd2;
        expect_op("busy_x1", 1, 32'h0, 1'b1, 4'd7, 4'd7);
        expect_op("busy_x2", 2, 32'h0, 1'b1, 4'd8, 4'd8);
        tick(); clear = 1'b1; issue(5'd7, 4'd9); commit(5'd9, 4'd0, 32'h99);
        tick(); rs1 = 5'd1; rs2 = 5'd2;
        expect_op("clear_x1", 1, 32'h0, 1'b0, 0, 4'd7);
        expect_op("clear_x2", 2, 32'h0, 1'b0, 0, 4'd8);
        tick(); rs1 = 5'd7; rs2 = 5'd4;
        expect_op("clear_x7", 1, 32'h0, 1'b0, 0, 4'd0);
        expect_op("clear_x4_val", 2, 32'd7, 1'b0, 0, 4'd5);
        tick(); rs1 = 5'd6; rs2 = 5'd9;
        expect_op("clear_x6_val", 1, 32'd9, 1'b0, 0, 4'd3);
        expect_op("clear_commit_x9", 2, 32'h99, 1'b0, 0, 4'd0);

        // rdy_in low freezes state.
        tick(); rdy_in = 1'b0; commit(5'd10, 4'd0, 32'h10); issue(5'd11, 4'd4); rs1 = 5'd10;
        expect_op("stall_x10", 1, 32'h0, 1'b0, 0, 0);
        tick(); rs1 = 5'd10; rs2 = 5'd11;
        expect_op("stall_after_x10", 1, 32'h0, 1'b0, 0, 0);
        expect_op("stall_after_x11", 2, 32'h0, 1'b0, 0, 0);

        // x0 writes are ignored.
        tick(); issue(5'd0, 4'd3); commit(5'd0, 4'd0, 32'hFFFF);
        tick(); rs1 = 5'd0; rs2 = 5'd0;
        expect_op("x0_rs1", 1, 32'h0, 1'b0, 0, 0);
        expect_op("x0_rs2", 2, 32'h0, 1'b0, 0, 0);

        // Asynchronous reset mid-run with x5 busy.
        tick(); issue(5'd5, 4'd1);
        tick(); rs1 = 5'd5;
        expect_op("busy_x5", 1, 32'h0, 1'b1, 4'd1, 4'd1);
        tick(); rst_in = 1'b1; rs1 = 5'd5; rs2 = 5'd4;
        expect_op("async_rst_x5", 1, 32'h0, 1'b0, 0, 0);
        expect_op("async_rst_x4", 2, 32'h0, 1'b0, 0, 0);
        tick(); rst_in = 1'b0;

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk_in);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the out-of-order core.
- Sits at the other end of the reorder-buffer commit and search interfaces:
  - consumes in-order commits (rob id, reg id, value);
  - records the producing ROB entry of each register at issue;
  - resolves decoder operand requests to either a ready value or a pending ROB id, probing the ROB search ports for already-written results.

Parameters:
ROB_WIDTH, 4, bit width of a ROB entry id (ROB_SIZE = 2**ROB_WIDTH)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global ready; state frozen when low
clear  input  1  misprediction flush from ROB; drops all rename tags
dec_ready  input  1  decoder issues an instruction this cycle
dec_rd  input  5  destination register of issued instruction
dec_rob_id  input  ROB_WIDTH  ROB entry allocated to issued instruction
rs1  input  5  source register 1 queried by decoder
rs2  input  5  source register 2 queried by decoder
val1  output  32  operand 1 value (valid when dep1=0)
dep1  output  1  operand 1 still pending
dep_rob_id1  output  ROB_WIDTH  ROB id producing operand 1 (valid when dep1=1)
val2  output  32  operand 2 value
dep2  output  1  operand 2 pending
dep_rob_id2  output  ROB_WIDTH  ROB id producing operand 2
search_rob_id_1  output  ROB_WIDTH  tag of rs1 sent to ROB search port 1
search_ready_1  input  1  ROB reports that entry has a result
search_val_1  input  32  ROB result for entry
search_rob_id_2  output  ROB_WIDTH  tag of rs2 sent to ROB search port 2
search_ready_2  input  1  ROB result ready, port 2
search_val_2  input  32  ROB result, port 2
commit_ready  input  1  ROB commits a register write
commit_rob_id  input  ROB_WIDTH  ROB entry being committed
commit_reg_id  input  5  destination register of commit
commit_val  input  32  committed value

Behaviour:
- State: 32 x {value[31:0], busy, tag[ROB_WIDTH-1:0]}.
- Register x0: reads 0, never busy; writes and issues to x0 are ignored.
- Reset (async, rst_in=1): all values, busy bits and tags = 0. Combinational outputs then read val=0, dep=0, dep_rob_id=0, search_rob_id=0.
- All state updates occur on posedge clk_in only when rdy_in=1. With rdy_in=0, nothing changes.
- Commit (commit_ready=1, reg != 0):
  - value[reg] <= commit_val.
  - busy[reg] <= 0 only if tag[reg]==commit_rob_id and no same-cycle issue renames reg.
- Issue (dec_ready=1, dec_rd != 0, clear=0): busy[dec_rd] <= 1, tag[dec_rd] <= dec_rob_id.
- Issue and commit to the same reg in the same cycle:
  - value takes commit_val;
  - busy stays 1;
  - tag takes dec_rob_id (issue wins).
- Clear (clear=1):
  - all busy <= 0; tags left as-is; issue that cycle is ignored;
  - commit that cycle still writes its value.
- Operand lookup, per port, purely combinational from current state and inputs. search_rob_id_n = tag[rs_n] always. Priority:
  1. rs_n == 0 -> val 0, dep 0.
  2. busy=0 -> val = value[rs_n], dep 0.
  3. busy=1 and commit_ready and commit_reg_id==rs_n and commit_rob_id==tag -> val = commit_val, dep 0 (commit bypass).
  4. busy=1 and search_ready_n -> val = search_val_n, dep 0.
  5. Otherwise -> dep 1, dep_rob_id = tag, val = 0.
- Lookup reads pre-issue state. An instruction whose rs equals its own rd sees the previous producer, not itself.
- No internal latency beyond one-cycle register update. Lookup results are valid in the same cycle as the query.

Test Plan:
- Reset mid-run with x5 busy: assert rst_in asynchronously -> immediately rs1=5 gives val1=0, dep1=0.
- Issue rd=3, rob_id=2; next cycle query rs1=3 with search_ready_1=0 -> dep1=1, dep_rob_id1=2, search_rob_id_1=2. Then search_ready_1=1, search_val_1=0x55 -> dep1=0, val1=0x55.
- Commit reg 3, rob 2, val 0xDEADBEEF -> same-cycle rs2=3 bypass gives val2=0xDEADBEEF, dep2=0. Next cycle busy[3]=0 and value reads 0xDEADBEEF.
- Stale commit: issue rd=4 rob 1, then issue rd=4 rob 5, then commit rob 1 val 7 -> value[4]=7, still dep with dep_rob_id=5.
- Same-cycle issue rd=6 rob 3 with commit reg 6 rob 0 val 9 -> value[6]=9, busy=1, tag=3.
- clear=1 with x1,x2 busy and dec_ready=1 rd=7 -> afterwards x1,x2,x7 all dep=0. Hold rdy_in=0 with a commit present -> no state change.
- Writes to x0 via issue and commit -> rs1=0 always returns val1=0, dep1=0.
